// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and byte-FSM state encoding for the UART
//                word receiver (oversampling ratio, data width, default
//                baud divider).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int DATA_BITS    = 8;
    localparam int BAUD_DIV_DEF = 327;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_word_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_word_if
//  Description : Valid/ready word handshake between the UART word receiver
//                (master, produces words) and its consumer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_word_if;

    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;

    modport master (
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        output word_ready
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_word_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : 8N1 UART byte receiver. Two-flop input synchronizer,
//                free-running oversample tick, 16x oversampling byte FSM.
//                Emits one-cycle byte_valid / frame_err pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       rx_i,
    output logic            byte_valid_o,
    output logic [7:0]      byte_data_o,
    output logic            frame_err_o,
    output logic            tick_o,
    output logic            idle_o
);

    localparam int              CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [3:0]      S_MID     = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]      S_LAST    = 4'(OVERSAMPLE - 1);
    localparam logic [2:0]      N_LAST    = 3'(DATA_BITS - 1);

    logic            rx_meta_q;
    logic            rx_s_q;
    logic [CW-1:0]   tick_cnt_q;
    rx_state_e       state_q;
    logic [3:0]      s_q;
    logic [2:0]      n_q;
    logic [7:0]      shift_q;
    logic            byte_valid_q;
    logic [7:0]      byte_data_q;
    logic            frame_err_q;

    // Bring the asynchronous serial line into the clk domain (idle high).
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_q <= '0;
        end else if (tick_cnt_q == BAUD_LAST) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    assign tick_o = (tick_cnt_q == BAUD_LAST);

    // Byte FSM: start edge is caught on any clk, all bit timing runs on tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            n_q          <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= ST_START;
                        s_q     <= '0;
                    end
                end
                ST_START: begin
                    if (tick_o) begin
                        if (s_q == S_MID) begin
                            // A start bit that is gone by mid-bit was a glitch.
                            if (!rx_s_q) begin
                                state_q <= ST_DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            s_q <= s_q + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick_o) begin
                        if (s_q == S_LAST) begin
                            shift_q <= {rx_s_q, shift_q[7:1]};
                            s_q     <= '0;
                            if (n_q == N_LAST) begin
                                state_q <= ST_STOP;
                            end else begin
                                n_q <= n_q + 3'd1;
                            end
                        end else begin
                            s_q <= s_q + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick_o) begin
                        if (s_q == S_LAST) begin
                            if (rx_s_q) begin
                                byte_valid_q <= 1'b1;
                                byte_data_q  <= shift_q;
                            end else begin
                                frame_err_q  <= 1'b1;
                            end
                            state_q <= ST_IDLE;
                        end else begin
                            s_q <= s_q + 4'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign idle_o       = (state_q == ST_IDLE);
    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign frame_err_o  = frame_err_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_word.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_word
//  Description : UART receiver that reassembles WORD_BYTES bytes (first byte
//                into the MS byte) into a 32-bit word with a valid/ready
//                hand-off, overrun detection and optional idle timeout.
//  Config      : define FRAME_TIMEOUT_EN to build the partial-word idle
//                timeout; otherwise timeout is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int BAUD_DIV      = BAUD_DIV_DEF,
    parameter int WORD_BYTES    = 4,
    parameter int TIMEOUT_TICKS = 320
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       rx,
    output logic            byte_valid,
    output logic [7:0]      byte_data,
    output logic            frame_err,
    output logic            overrun,
    output logic            timeout,
    uart_rx_word_if.master  word_if
);

    localparam int            IW       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WORD_BYTES - 1);

    logic            w_bv;
    logic [7:0]      w_bd;
    logic            w_fe;
    logic            w_tick;
    logic            w_idle;
    logic            w_accept;
    logic            w_tmo_hit;

    logic [31:0]     acc_q;
    logic [IW-1:0]   idx_q;
    logic            word_valid_q;
    logic [31:0]     word_data_q;
    logic            overrun_q;

    uart_rx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (rx),
        .byte_valid_o (w_bv),
        .byte_data_o  (w_bd),
        .frame_err_o  (w_fe),
        .tick_o       (w_tick),
        .idle_o       (w_idle)
    );

    assign w_accept = word_valid_q && word_if.word_ready;

    // Word assembly and hand-off; a completion may replace a word accepted in the same clk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q        <= '0;
            idx_q        <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (w_accept) begin
                word_valid_q <= 1'b0;
            end
            if (w_bv) begin
                acc_q <= {acc_q[23:0], w_bd};
                if (idx_q == IDX_LAST) begin
                    idx_q <= '0;
                    if (!word_valid_q || w_accept) begin
                        word_data_q  <= {acc_q[23:0], w_bd};
                        word_valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end else if (w_fe || w_tmo_hit) begin
                idx_q <= '0;
            end
        end
    end

`ifdef FRAME_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          timeout_q;

    assign w_tmo_hit = w_tick && w_idle && (idx_q != '0) && (tmo_cnt_q == TMO_LAST)
                       && !w_bv && !w_fe;

    // Idle-tick counter that abandons a stalled partial word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= w_tmo_hit;
            if (w_bv || (idx_q == '0) || w_tmo_hit) begin
                tmo_cnt_q <= '0;
            end else if (w_tick && w_idle) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign timeout      = 1'b0;
    assign w_unused_tmo = w_tick ^ w_idle ^ (TIMEOUT_TICKS == 0);
`endif

    assign byte_valid         = w_bv;
    assign byte_data          = w_bd;
    assign frame_err          = w_fe;
    assign overrun            = overrun_q;
    assign word_if.word_valid = word_valid_q;
    assign word_if.word_data  = word_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_word
//  Description : Self-checking bench for uart_rx_word (BAUD_DIV=4, 64 clk
//                per bit). Directed scenarios plus random words and frame
//                errors, checked against a byte/word reference model.
//  Config      : timeout scenario built only with FRAME_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_word;

    localparam int BIT_CLK = 64;
    localparam int NBYTES  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    logic       overrun;
    logic       timeout;

    uart_rx_word_if wif ();

    uart_rx_word #(
        .BAUD_DIV      (4),
        .WORD_BYTES    (NBYTES),
        .TIMEOUT_TICKS (320)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .timeout    (timeout),
        .word_if    (wif.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- observed events (sampled mid-cycle) ----------------
    logic [7:0]  got_bytes[$];
    logic [31:0] got_words[$];
    int got_fe = 0, got_ovr = 0, got_tmo = 0;

    always @(negedge clk) begin
        #1;
        if (byte_valid) got_bytes.push_back(byte_data);
        if (frame_err)  got_fe++;
        if (overrun)    got_ovr++;
        if (timeout)    got_tmo++;
        if (wif.word_valid && wif.word_ready) got_words.push_back(wif.word_data);
    end

    // ---------------- reference model ----------------
    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_words[$];
    logic [7:0]  part[$];
    int exp_fe = 0, exp_ovr = 0, exp_tmo = 0;
    bit          m_pend = 0;
    logic [31:0] m_pend_word = '0;
    int          rmode = 1;   // 1: ready held high, 0: held low, 2: accept coincides with completion

    task automatic model_good(input logic [7:0] b);
        logic [31:0] w;
        exp_bytes.push_back(b);
        part.push_back(b);
        if (part.size() == NBYTES) begin
            w = {part[0], part[1], part[2], part[3]};
            part.delete();
            if (rmode == 1) begin
                exp_words.push_back(w);
            end else if (rmode == 0) begin
                if (m_pend) exp_ovr++;
                else begin
                    m_pend      = 1;
                    m_pend_word = w;
                end
            end else begin
                exp_words.push_back(m_pend_word);
                m_pend_word = w;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic send_frame(input logic [7:0] b, input bit stop);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        if (stop) begin
            rx = 1'b1;
            repeat (BIT_CLK) @(negedge clk);
        end else begin
            // Low past the stop sample, then released well before a restart could sample it.
            rx = 1'b0;
            repeat (48) @(negedge clk);
            rx = 1'b1;
            repeat (128) @(negedge clk);
        end
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b1);
        model_good(b);
    endtask

    task automatic send_bad(input logic [7:0] b);
        send_frame(b, 1'b0);
        exp_fe++;
        part.delete();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_good(w[8*i +: 8]);
    endtask

    task automatic sync_check(input string tag);
        repeat (8) @(negedge clk);
        check({tag, "_nbytes"}, got_bytes.size(), exp_bytes.size());
        while (got_bytes.size() > 0 && exp_bytes.size() > 0)
            check({tag, "_byte"}, {24'h0, got_bytes.pop_front()}, {24'h0, exp_bytes.pop_front()});
        check({tag, "_nwords"}, got_words.size(), exp_words.size());
        while (got_words.size() > 0 && exp_words.size() > 0)
            check({tag, "_word"}, got_words.pop_front(), exp_words.pop_front());
        got_bytes.delete(); exp_bytes.delete();
        got_words.delete(); exp_words.delete();
        check({tag, "_frame_err"}, got_fe, exp_fe);
        check({tag, "_overrun"}, got_ovr, exp_ovr);
        check({tag, "_timeout"}, got_tmo, exp_tmo);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bv"},  {31'h0, byte_valid}, 32'h0);
        check({tag, "_bd"},  {24'h0, byte_data}, 32'h0);
        check({tag, "_fe"},  {31'h0, frame_err}, 32'h0);
        check({tag, "_ovr"}, {31'h0, overrun}, 32'h0);
        check({tag, "_tmo"}, {31'h0, timeout}, 32'h0);
        check({tag, "_wv"},  {31'h0, wif.word_valid}, 32'h0);
        check({tag, "_wd"},  wif.word_data, 32'h0);
    endtask

    initial begin
        bit          hit;
        logic [31:0] rw;

        wif.word_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        repeat (16) @(negedge clk);

        // 1: back-to-back word
        send_word(32'hDEADBEEF);
        sync_check("t1");

        // 2: short low glitch is ignored
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (128) @(negedge clk);
        sync_check("t2");

        // 3: framing error drops a partial word
        send_good(8'hA1);
        send_good(8'hA2);
        send_bad(8'h55);
        send_word(32'h01020304);
        sync_check("t3");

        // 4: consumer stalled -> second word overruns
        rmode = 0;
        wif.word_ready = 1'b0;
        send_word(32'h11111111);
        send_word(32'h22222222);
        repeat (8) @(negedge clk);
        check("t4_wv", {31'h0, wif.word_valid}, 32'h1);
        check("t4_wd", wif.word_data, 32'h11111111);
        wif.word_ready = 1'b1;
        @(negedge clk);
        wif.word_ready = 1'b0;
        exp_words.push_back(m_pend_word);
        m_pend = 0;
        repeat (2) @(negedge clk);
        check("t4_wv_after", {31'h0, wif.word_valid}, 32'h0);
        check("t4_wd_hold", wif.word_data, 32'h11111111);
        sync_check("t4");

        // 5: completion in the same clk as acceptance
        send_word(32'h11111111);
        send_good(8'hCA);
        send_good(8'hFE);
        send_good(8'hF0);
        rmode = 2;
        hit = 0;
        fork
            send_good(8'h0D);
            begin
                for (int k = 0; k < 1000; k++) begin
                    @(negedge clk);
                    if (byte_valid) begin
                        hit = 1;
                        break;
                    end
                end
                wif.word_ready = 1'b1;
                @(negedge clk);
                wif.word_ready = 1'b0;
            end
        join
        check("t5_bv_seen", {31'h0, hit}, 32'h1);
        rmode = 0;
        repeat (4) @(negedge clk);
        check("t5_wv", {31'h0, wif.word_valid}, 32'h1);
        check("t5_wd", wif.word_data, 32'hCAFEF00D);
        sync_check("t5");
        rmode = 1;
        wif.word_ready = 1'b1;
        exp_words.push_back(m_pend_word);
        m_pend = 0;
        sync_check("t5b");

        // random bytes with occasional framing errors
        for (int e = 0; e < 28; e++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            if ($urandom_range(0, 9) == 0) send_bad(8'($urandom));
            else send_good(8'($urandom));
        end
        sync_check("rand");

        // reset mid-byte of the second byte discards everything
        send_good(8'h12);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_zero("mid_reset");
        reset = 1'b1;
        part.delete();
        repeat (128) @(negedge clk);
        rw = $urandom;
        send_word(rw);
        sync_check("post_reset");

`ifdef FRAME_TIMEOUT_EN
        // 6: idle partial word is abandoned
        send_good(8'hAA);
        send_good(8'hBB);
        repeat (400 * 4) @(negedge clk);
        exp_tmo++;
        part.delete();
        send_word(32'h11223344);
        sync_check("t6");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
